// File: rtl/mem_pkg.sv
// Shared definitions for the data memory port and the block-copy engine.
// State codes and default widths are common to the memory and its initiators.
package mem_pkg;

    localparam int MEM_DW = 16;
    localparam int MEM_AW = 16;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_READ   = 2'd1;
    localparam logic [1:0] S_WRITE  = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = S_IDLE,
        ST_READ   = S_READ,
        ST_WRITE  = S_WRITE,
        ST_FINISH = S_FINISH
    } state_e;

endpackage

// File: rtl/mem_copy_engine.sv
// Block-copy initiator: reads len words from src and writes them to dst,
// one READ/WRITE cycle pair per word, strictly ascending.
//
// state  | meaning
// IDLE   | waiting for start; memory port released
// READ   | memr asserted at sp, read_data captured into dbuf
// WRITE  | memw asserted at dp with dbuf; pointers advance, cnt decrements
// FINISH | one-cycle done pulse
module mem_copy_engine
    import mem_pkg::*;
#(
    parameter int DW        = MEM_DW,
    parameter int AW        = MEM_AW,
    parameter int ADDR_STEP = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [AW-1:0] len,
    output logic [AW-1:0] address,
    output logic [DW-1:0] write_data,
    output logic          memw,
    output logic          memr,
    input  logic [DW-1:0] read_data,
    output logic          busy,
    output logic          done,
    output logic          aborted,
    output logic [AW-1:0] remaining
);

    state_e        state, state_nxt;
    logic [AW-1:0] sp, sp_nxt;
    logic [AW-1:0] dp, dp_nxt;
    logic [AW-1:0] cnt, cnt_nxt;
    logic [DW-1:0] dbuf, dbuf_nxt;
    logic          aborted_q, aborted_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            sp        <= '0;
            dp        <= '0;
            cnt       <= '0;
            dbuf      <= '0;
            aborted_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            sp        <= sp_nxt;
            dp        <= dp_nxt;
            cnt       <= cnt_nxt;
            dbuf      <= dbuf_nxt;
            aborted_q <= aborted_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        sp_nxt      = sp;
        dp_nxt      = dp;
        cnt_nxt     = cnt;
        dbuf_nxt    = dbuf;
        aborted_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    sp_nxt    = src;
                    dp_nxt    = dst;
                    cnt_nxt   = len;
                    state_nxt = (len == '0) ? ST_FINISH : ST_READ;
                end
            end
            ST_READ: begin
                dbuf_nxt  = read_data;
                state_nxt = ST_WRITE;
                if (abort) begin
                    state_nxt   = ST_IDLE;
                    aborted_nxt = 1'b1;
                end
            end
            ST_WRITE: begin
                // The write commits on this edge even when aborted, so the
                // bookkeeping advances regardless.
                sp_nxt    = sp + AW'(ADDR_STEP);
                dp_nxt    = dp + AW'(ADDR_STEP);
                cnt_nxt   = cnt - AW'(1);
                state_nxt = (cnt == AW'(1)) ? ST_FINISH : ST_READ;
                if (abort) begin
                    state_nxt   = ST_IDLE;
                    aborted_nxt = 1'b1;
                end
            end
            ST_FINISH: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    assign memr       = (state == ST_READ);
    assign memw       = (state == ST_WRITE);
    assign busy       = memr | memw;
    assign done       = (state == ST_FINISH);
    assign aborted    = aborted_q;
    assign remaining  = cnt;
    assign address    = memr ? sp : (memw ? dp : '0);
    assign write_data = memw ? dbuf : '0;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine: a word-array data memory responds
// on the port, and a shadow array tracks what memory should hold.
module tb_mem_copy_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] src = '0, dst = '0, len = '0;
    logic [15:0] address, write_data, read_data, remaining;
    logic        memw, memr, busy, done, aborted;

    logic        pl_we = 1'b0;
    logic [15:0] pl_addr = '0, pl_data = '0;

    logic [15:0] mem       [0:65535] = '{default: 16'h0};
    logic [15:0] model_mem [0:65535] = '{default: 16'h0};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_copy_engine dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .src(src), .dst(dst), .len(len),
        .address(address), .write_data(write_data), .memw(memw), .memr(memr),
        .read_data(read_data), .busy(busy), .done(done), .aborted(aborted),
        .remaining(remaining)
    );

    assign read_data = memr ? mem[address] : 16'h0;

    always @(posedge clk) begin
        if (memw)       mem[address] <= write_data;
        else if (pl_we) mem[pl_addr] <= pl_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Port protocol holds on every cycle regardless of the scenario.
    always @(negedge clk) begin
        chk("rw_exclusive", {31'b0, memr & memw}, 32'd0);
        chk("busy_vs_port", {31'b0, busy}, {31'b0, memr | memw});
        if (!memr && !memw) chk("idle_address", {16'b0, address}, 32'd0);
        if (!memw)          chk("idle_wdata", {16'b0, write_data}, 32'd0);
    end

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        model_mem[a] = d;
    endtask

    task automatic preload_end();
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    task automatic check_mem(input string tag);
        int bad = 0;
        int first = -1;
        for (int i = 0; i < 65536; i++)
            if (mem[i] !== model_mem[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        chk(tag, bad, 0);
        if (bad != 0) $display("  first differing word at %0h", first);
    endtask

    // abort_k > 0 raises abort during the abort_k-th WRITE cycle;
    // restart_c > 0 issues a stray start in that cycle of the copy.
    task automatic run_copy(input string tag, input logic [15:0] s, input logic [15:0] d,
                            input logic [15:0] l, input int abort_k, input int restart_c);
        int n_words, limit, done_c, ab_c, busy_n;
        logic [15:0] ab_rem;
        logic [15:0] rq[$];
        logic [15:0] wq[$];
        int addr_bad;
        n_words = (abort_k > 0) ? abort_k : int'(l);
        for (int i = 0; i < n_words; i++)
            model_mem[16'(d + 16'(i))] = model_mem[16'(s + 16'(i))];
        limit  = 2 * int'(l) + 6;
        done_c = 0; ab_c = 0; busy_n = 0; ab_rem = '0;
        @(negedge clk);
        src = s; dst = d; len = l; start = 1'b1;
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk);
            start = 1'b0; abort = 1'b0;
            if (c == 1) chk({tag, ".remaining_initial"}, {16'b0, remaining}, {16'b0, l});
            if (busy) busy_n++;
            if (memr) rq.push_back(address);
            if (memw) wq.push_back(address);
            if (abort_k > 0 && c == 2 * abort_k) abort = 1'b1;
            if (c == restart_c) begin
                start = 1'b1; src = s + 16'd100; dst = d + 16'd7; len = 16'd2;
            end
            if (done) begin
                done_c = c;
                start = 1'b1; src = s + 16'd50; dst = d + 16'd3; len = 16'd3;
                break;
            end
            if (aborted) begin
                ab_c = c; ab_rem = remaining;
                break;
            end
        end
        @(negedge clk);
        start = 1'b0;
        chk({tag, ".idle_after_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, ".no_late_done"}, {30'b0, done, aborted}, 32'd0);
        if (abort_k == 0) begin
            chk({tag, ".done_cycle"}, done_c, 2 * int'(l) + 1);
            chk({tag, ".no_aborted"}, ab_c, 0);
            chk({tag, ".busy_cycles"}, busy_n, 2 * int'(l));
        end else begin
            chk({tag, ".aborted_cycle"}, ab_c, 2 * abort_k + 1);
            chk({tag, ".no_done"}, done_c, 0);
            chk({tag, ".remaining_after_abort"}, {16'b0, ab_rem}, {16'b0, l - 16'(abort_k)});
            chk({tag, ".busy_cycles"}, busy_n, 2 * abort_k);
        end
        chk({tag, ".read_count"}, rq.size(), n_words);
        chk({tag, ".write_count"}, wq.size(), n_words);
        addr_bad = 0;
        for (int i = 0; i < n_words && i < rq.size() && i < wq.size(); i++) begin
            if (rq[i] !== 16'(s + 16'(i))) addr_bad++;
            if (wq[i] !== 16'(d + 16'(i))) addr_bad++;
        end
        chk({tag, ".address_sequence"}, addr_bad, 0);
        check_mem({tag, ".memory"});
    endtask

    initial begin
        logic [15:0] rs, rd, rl;
        int ak;

        // Reset holds everything at zero, start ignored.
        start = 1'b1; len = 16'd3;
        repeat (3) @(negedge clk);
        chk("reset.outputs", {address, write_data}, 32'd0);
        chk("reset.flags", {27'b0, memw, memr, busy, done, aborted}, 32'd0);
        chk("reset.remaining", {16'b0, remaining}, 32'd0);
        start = 1'b0; len = '0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset.idle_after_release", {29'b0, busy, done, aborted}, 32'd0);

        preload(16'd0, 16'd11); preload(16'd1, 16'd22); preload(16'd2, 16'd33);
        preload_end();
        run_copy("basic", 16'd0, 16'd8, 16'd3, 0, 0);

        run_copy("zero_len", 16'd0, 16'd20, 16'd0, 0, 0);

        preload(16'hFFFE, 16'hA1); preload(16'hFFFF, 16'hB2); preload(16'h0000, 16'hC3);
        preload_end();
        run_copy("wrap", 16'hFFFE, 16'd4, 16'd3, 0, 0);

        for (int i = 0; i < 5; i++) preload(16'(16'd30 + 16'(i)), 16'(16'h100 + 16'(i)));
        preload_end();
        run_copy("abort", 16'd30, 16'd60, 16'd5, 2, 0);

        for (int i = 0; i < 4; i++) preload(16'(i), 16'(i + 1));
        preload_end();
        run_copy("overlap", 16'd0, 16'd1, 16'd3, 0, 3);

        // Reset mid-copy: two words already committed remain, no pulses.
        for (int i = 0; i < 4; i++) preload(16'(16'd200 + 16'(i)), 16'(16'h5A0 + 16'(i)));
        preload_end();
        model_mem[240] = model_mem[200];
        model_mem[241] = model_mem[201];
        @(negedge clk);
        src = 16'd200; dst = 16'd240; len = 16'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset.flags", {27'b0, memw, memr, busy, done, aborted}, 32'd0);
        chk("midreset.remaining", {16'b0, remaining}, 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("midreset.no_pulse", {30'b0, done, aborted}, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("midreset.stays_idle", {29'b0, busy, done, aborted}, 32'd0);
        check_mem("midreset.memory");

        // Randomized copies, some aborted, some near the top of the address space.
        for (int t = 0; t < 20; t++) begin
            rs = 16'($urandom_range(0, 63));
            if (t % 5 == 4) rs = 16'hFFFC + 16'($urandom_range(0, 3));
            rd = 16'($urandom_range(0, 80));
            rl = 16'($urandom_range(0, 8));
            ak = (rl != 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, int'(rl))) : 0;
            for (int i = 0; i < int'(rl); i++)
                preload(16'(rs + 16'(i)), 16'($urandom));
            preload_end();
            run_copy($sformatf("rand%0d", t), rs, rd, rl, ak, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
